// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// well-known keyboard command bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus a run-length glitch filter for one PS/2 line.
// Emits the filtered level and a one-cycle strobe on each filtered 1->0 edge.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q;

  // The level only moves after FILTER_LEN consecutive synchronised samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        fall_q  <= level_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out data/parity/stop on device clock falls and checks the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_i  (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .reset   (reset),
    .line_i  (ps2_data_in),
    .level_o (data_level),
    .fall_o  (unused_data_fall)
  );

  state_e        state_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic          nack_q;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] inh_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic          clk_oe_q;
  logic          data_oe_q;
  logic          done_q;
  logic          ack_err_q;
  logic          timeout_q;

  // A done/timeout pulse cycle still counts as busy; the FSM returns to IDLE one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      nack_q    <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      if (done_q || timeout_q) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (tx_valid) begin
              shift_q   <= tx_data;
              parity_q  <= odd_parity(tx_data);
              inh_cnt_q <= '0;
              clk_oe_q  <= 1'b1;
              state_q   <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
              clk_oe_q <= 1'b0;
              state_q  <= REQ;
            end else begin
              inh_cnt_q <= inh_cnt_q + IW'(1);
              if (inh_cnt_q == IW'(INHIBIT_CYCLES - 2)) begin
                data_oe_q <= 1'b1;
              end
            end
          end
          REQ: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            state_q   <= DATA;
          end
          default: begin
            // Timeout takes priority over any fall seen in the same cycle.
            if (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b0;
              timeout_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + TW'(1);
              if (state_q == DATA && clk_fall) begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q < 4'd8) begin
                  data_oe_q <= ~shift_q[0];
                  shift_q   <= {1'b0, shift_q[7:1]};
                end else if (bit_cnt_q == 4'd8) begin
                  data_oe_q <= ~parity_q;
                end else begin
                  data_oe_q <= 1'b0;
                  state_q   <= ACK;
                end
              end else if (state_q == ACK && clk_fall) begin
                nack_q  <= data_level;
                state_q <= WAIT_IDLE;
              end else if (state_q == WAIT_IDLE && clk_level && data_level) begin
                done_q    <= 1'b1;
                ack_err_q <= nack_q;
              end
            end
          end
        endcase
      end
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: an inline PS/2 device model clocks frames
// out of the transmitter and acks, nacks, glitches or stays silent.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 4000;
  localparam int FLEN    = 4;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       dev_clk;
  logic       dev_data;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_LEN    (FLEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  int   cycleCount       = 0;
  int   doneCount        = 0;
  int   ackErrWithDone   = 0;
  int   ackErrAlone      = 0;
  int   timeoutCount     = 0;
  int   timeoutOeBad     = 0;
  int   clkOeCycles      = 0;
  int   readyLate        = 0;
  int   lastReleaseCycle = 0;
  int   lastTimeoutCycle = 0;
  logic prevPulse        = 1'b0;
  logic prevClkOe        = 1'b0;

  // Cumulative event counters sampled mid-cycle; directed steps compare deltas.
  always @(negedge clk) begin
    cycleCount++;
    if (ps2_clk_oe) clkOeCycles++;
    if (prevClkOe && !ps2_clk_oe) lastReleaseCycle = cycleCount;
    if (done) doneCount++;
    if (done && ack_err) ackErrWithDone++;
    if (ack_err && !done) ackErrAlone++;
    if (timeout) begin
      timeoutCount++;
      lastTimeoutCycle = cycleCount;
      if (ps2_clk_oe || ps2_data_oe) timeoutOeBad++;
    end
    if (prevPulse && !tx_ready) readyLate++;
    prevPulse = done | timeout;
    prevClkOe = ps2_clk_oe;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!tx_ready && guard < 2000) begin
      tick(1);
      guard++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    checkOutput("ready_drops_after_accept", {31'd0, tx_ready}, 32'd0);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic waitRelease(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && !ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic deviceClock(input int nBits, input bit glitch, output logic [10:0] rx);
    rx    = '0;
    rx[0] = ps2_data_in;
    for (int k = 1; k <= nBits; k++) begin
      if (glitch && k >= 2) begin
        tick(15);
        dev_clk = 1'b0;
        tick(2);
        dev_clk = 1'b1;
        tick(HALF - 17);
      end else begin
        tick(HALF);
      end
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      rx[k]   = ps2_data_in;
    end
  endtask

  task automatic deviceAck(input bit ackIt);
    dev_data = ~ackIt;
    tick(HALF / 2);
    dev_clk = 1'b0;
    tick(HALF);
    dev_clk = 1'b1;
    tick(10);
    dev_data = 1'b1;
  endtask

  task automatic waitPulse(input int d0, input int t0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (doneCount != d0 || timeoutCount != t0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic runFrame(input logic [7:0] b, input bit ackIt, input bit glitch, input bit poke,
                          input logic [10:0] expFrame, input string tag);
    int d0, e0, t0;
    bit ok;
    logic [10:0] rx;
    d0 = doneCount;
    e0 = ackErrWithDone;
    t0 = timeoutCount;
    applyStimulus(b);
    if (poke) begin
      tx_data  = 8'h11;
      tx_valid = 1'b1;
      tick(5);
      tx_valid = 1'b0;
    end
    waitRelease(ok);
    checkOutput({tag, "_release"}, {31'd0, ok}, 32'd1);
    deviceClock(10, glitch, rx);
    deviceAck(ackIt);
    waitPulse(d0, t0, 300, ok);
    checkOutput({tag, "_pulse_seen"}, {31'd0, ok}, 32'd1);
    checkOutput({tag, "_frame"}, {21'd0, rx}, {21'd0, expFrame});
    checkOutput({tag, "_done_count"}, doneCount - d0, 32'd1);
    checkOutput({tag, "_ack_err_count"}, ackErrWithDone - e0, ackIt ? 32'd0 : 32'd1);
    checkOutput({tag, "_no_timeout"}, timeoutCount - t0, 32'd0);
    checkOutput({tag, "_ready_after"}, {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin
    int c0, d0, t0, lat;
    bit ok;
    logic [10:0] rxPart;

    reset    = 1'b1;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick(3);
    checkOutput("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ack_err", {31'd0, ack_err}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
    reset = 1'b0;
    tick(10);

    // 0xED: start 0, LSB-first 1,0,1,1,0,1,1,1, parity 1, stop 1.
    c0 = clkOeCycles;
    runFrame(CMD_SET_LEDS, 1'b1, 1'b0, 1'b0, 11'h7DA, "ed_ack");
    checkOutput("ed_clk_oe_cycles", clkOeCycles - c0, 32'd20);

    runFrame(8'h07, 1'b1, 1'b0, 1'b0, 11'h40E, "x07_ack");
    runFrame(8'h00, 1'b1, 1'b0, 1'b0, 11'h600, "x00_ack");
    runFrame(CMD_SET_LEDS, 1'b0, 1'b0, 1'b0, 11'h7DA, "ed_nack");

    $display("[TB] silent device, expecting timeout");
    d0 = doneCount;
    t0 = timeoutCount;
    applyStimulus(8'h5A);
    waitRelease(ok);
    checkOutput("to_release", {31'd0, ok}, 32'd1);
    waitPulse(d0, t0, TIMEOUT + 200, ok);
    checkOutput("to_pulse_seen", {31'd0, ok}, 32'd1);
    checkOutput("to_timeout_count", timeoutCount - t0, 32'd1);
    checkOutput("to_no_done", doneCount - d0, 32'd0);
    checkOutput("to_oe_released", timeoutOeBad, 32'd0);
    lat = lastTimeoutCycle - lastReleaseCycle;
    checkOutput("to_latency_window", {31'd0, (lat >= TIMEOUT - 5 && lat <= TIMEOUT + 5)}, 32'd1);
    checkOutput("to_ready_after", {31'd0, tx_ready}, 32'd1);
    checkOutput("to_data_oe_after", {31'd0, ps2_data_oe}, 32'd0);

    runFrame(CMD_SET_LEDS, 1'b1, 1'b1, 1'b0, 11'h7DA, "ed_glitch");

    $display("[TB] reset during DATA");
    applyStimulus(8'h33);
    waitRelease(ok);
    checkOutput("mid_release", {31'd0, ok}, 32'd1);
    deviceClock(4, 1'b0, rxPart);
    checkOutput("mid_partial_frame", {27'd0, rxPart[4:0]}, 32'h6);
    checkOutput("mid_data_oe_before", {31'd0, ps2_data_oe}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    checkOutput("mid_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_tx_ready", {31'd0, tx_ready}, 32'd1);
    tick(2);
    reset = 1'b0;
    tick(10);

    runFrame(CMD_RESET, 1'b1, 1'b0, 1'b1, 11'h7FE, "ff_after_reset");
    tick(5);
    checkOutput("ff_no_second_transfer", {31'd0, busy}, 32'd0);
    checkOutput("ready_late_count", readyLate, 32'd0);
    checkOutput("ack_err_without_done", ackErrAlone, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the opposite direction of the existing PS/2 keyboard receiver, and lets the Atom send command bytes to the keyboard (for example 0xED set-LEDs, 0xFF reset). It sits beside the keyboard block in the clk_vga (25 MHz) domain and drives the PS/2 open-drain lines through output enables. The top level combines those enables with the existing ps2_clk/ps2_data pins.

Parameters:
INHIBIT_CYCLES, 2500, clock-low request hold (100 us at 25 MHz)
TIMEOUT_CYCLES, 375000, max cycles from request release to ack complete (15 ms)
FILTER_LEN, 4, consecutive equal samples required to accept a new filtered PS/2 line level

Ports:
clk  in  1  system clock (clk_vga)
reset  in  1  asynchronous, active-high reset
ps2_clk_in  in  1  raw PS/2 clock pin level
ps2_data_in  in  1  raw PS/2 data pin level
ps2_clk_oe  out  1  1 = pull PS/2 clock low
ps2_data_oe  out  1  1 = pull PS/2 data low
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid & tx_ready
tx_ready  out  1  idle, can accept a byte
busy  out  1  transfer in progress; the keyboard receiver ignores frames while high
done  out  1  1-cycle pulse, transfer finished and device acked
ack_err  out  1  1-cycle pulse with done, device did not ack (data high at ack)
timeout  out  1  1-cycle pulse, transfer aborted by timeout

Behaviour:
- Reset (async): state IDLE. ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_err=0, timeout=0. Filters preset to 1.
- Input conditioning: 2-FF synchroniser on each line, then FILTER_LEN glitch filter. A clock falling edge (fall) is a filtered-clock 1->0 transition. Input-to-fall latency is 2+FILTER_LEN cycles.
- Accept: on tx_valid & tx_ready, latch tx_data into shift register and compute parity = ~^tx_data (odd). tx_ready drops the next cycle. tx_valid while busy is ignored.
- States:
  IDLE -> INHIBIT on accept.
  INHIBIT: clk_oe=1 for INHIBIT_CYCLES. On the last cycle, data_oe=1 (start bit) -> REQ.
  REQ: clk_oe=0, data_oe=1. Clear bitcnt and timeout counter -> DATA.
  DATA: on each fall, bitcnt++. Falls 1-8 set data_oe=~shift[0], LSB first. Fall 9 sets data_oe=~parity. Fall 10 sets data_oe=0 (stop) -> ACK.
  ACK: on next fall, sample filtered data; 0 = ack, 1 = nack -> WAIT_IDLE.
  WAIT_IDLE: wait until filtered clock and data are both 1 -> IDLE. Pulse done (and ack_err if nack).
- Timeout: counter runs in REQ/DATA/ACK/WAIT_IDLE. On reaching TIMEOUT_CYCLES: both oe=0, pulse timeout (no done) -> IDLE.
- Timeout wins over a coincident fall.
- busy = state != IDLE. tx_ready = state == IDLE. tx_ready returns the cycle after done or timeout.
- Counter widths use $clog2 of their parameters. Counters saturate and never wrap.
- Noise on the clock line during INHIBIT is ignored; falls are only counted in DATA and ACK.
- Reset mid-transfer releases both lines immediately, drops pulses, and discards the byte.

Decomposition:
- Shared package ps2_pkg: state enum (IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE) and PS/2 command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA).
- One sub-module ps2_line_filter (synchroniser plus FILTER_LEN filter, outputs level and fall strobe), instantiated once for clock and once for data.

Test Plan:
Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=4000, FILTER_LEN=4. The device model runs 40-cycle clock half-periods and samples data on rising edges.
- Send 0xED, model acks -> model receives start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. done pulses once, ack_err=0, clk_oe high exactly 20 cycles.
- Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. Both done with ack_err=0.
- Model holds data high at ack fall -> done=1 and ack_err=1 in the same cycle, then tx_ready=1 the next cycle.
- Model never clocks after the request -> timeout pulse about 4000 cycles after REQ, both oe=0, no done, tx_ready=1.
- 2-cycle low glitches on ps2_clk_in during DATA -> no extra bits counted; frame identical to the 0xED case.
- Assert reset mid-DATA (after 4 bits) -> oe=0 at once (async), busy=0. Next 0xFF transfer completes correctly; tx_valid asserted while busy has no effect.
